// File: rtl/pcap_axi_lite_pkg.sv
// Shared definitions for the pcap AXI4-Lite register block:
// response codes, write-channel state type and the byte-lane merge helper.
package pcap_axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   // Byte b of the result comes from data when strb[b] is set, else from old
   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  strb
   );
      logic [31:0] v;
      for (int b = 0; b < 4; b++) begin
         v[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
      end
      return v;
   endfunction

endpackage

// File: rtl/pcap_reg_bank.sv
// Register storage for the pcap control port: NUM_REGS 32-bit registers with
// byte-strobed writes, a one-cycle write pulse per register and a registered
// read mux. Out-of-range indices never write and read back as zero.
module pcap_reg_bank
   import pcap_axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [IDX_W-1:0]         i_wr_idx,
   input  logic [31:0]              i_wr_data,
   input  logic [3:0]               i_wr_strb,
   input  logic                     i_rd_en,
   input  logic [IDX_W-1:0]         i_rd_idx,
   output logic [31:0]              o_rd_data,
   output logic [NUM_REGS*32-1:0]   o_reg_q,
   output logic [NUM_REGS-1:0]      o_wr_pulse
);

   logic [31:0] w_regs [NUM_REGS];
   logic [31:0] r_rd_data;
   logic        w_rd_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [31:0] r_val;
         logic        r_pulse;
         logic        w_we;

         assign w_we = i_wr_en && (int'(i_wr_idx) == gi);

         // Merge the strobed bytes into this register and flag the update
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_val   <= '0;
               r_pulse <= 1'b0;
            end else begin
               r_pulse <= w_we;
               if (w_we) begin
                  r_val <= merge(r_val, i_wr_data, i_wr_strb);
               end
            end
         end

         assign w_regs[gi]            = r_val;
         assign o_reg_q[gi*32 +: 32] = r_val;
         assign o_wr_pulse[gi]        = r_pulse;
      end
   endgenerate

   assign w_rd_ok = int'(i_rd_idx) < NUM_REGS;

   // Capture read data on request; sampling the pre-update value gives
   // old data when a read and a write to the same register share an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= w_rd_ok ? w_regs[i_rd_idx] : '0;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pcap_axi_lite_regs.sv
// AXI4-Lite responder for the pcap S00_AXI control port. Write address and
// write data are accepted independently and committed together; the read
// channel runs separately with a single outstanding request.
module pcap_axi_lite_regs
   import pcap_axi_lite_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]            reg_q,
   output logic [NUM_REGS-1:0]               reg_wr_pulse
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   // Write channel state and registered outputs
   wr_state_t                      r_wr_state;
   wr_state_t                      w_wr_state_next;
   logic                           r_awready;
   logic                           r_wready;
   logic                           r_aw_held;
   logic                           r_w_held;
   logic                           r_bvalid;
   logic [1:0]                     r_bresp;
   logic [IDX_W-1:0]               r_awidx;
   logic [C_S_AXI_DATA_WIDTH-1:0]  r_wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;

   logic                           w_awready_next;
   logic                           w_wready_next;
   logic                           w_aw_held_next;
   logic                           w_w_held_next;
   logic                           w_bvalid_next;
   logic [1:0]                     w_bresp_next;

   logic                           w_aw_hs;
   logic                           w_w_hs;
   logic                           w_aw_have;
   logic                           w_w_have;
   logic                           w_commit;
   logic                           w_b_hs;
   logic [IDX_W-1:0]               w_wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]  w_wr_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] w_wr_strb;
   logic                           w_wr_ok;

   // Read channel
   logic                           r_arready;
   logic                           r_rvalid;
   logic [1:0]                     r_rresp;
   logic                           w_ar_hs;
   logic                           w_r_hs;
   logic                           w_rvalid_next;
   logic [IDX_W-1:0]               w_rd_idx;
   logic                           w_rd_ok;

   // Protection bits and sub-word address bits carry no meaning here
   logic                           w_unused;
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ---------------------------------------------------------------
   // Write channel
   // ---------------------------------------------------------------
   assign w_aw_hs   = S_AXI_AWVALID && r_awready;
   assign w_w_hs    = S_AXI_WVALID  && r_wready;
   assign w_aw_have = r_aw_held || w_aw_hs;
   assign w_w_have  = r_w_held  || w_w_hs;
   assign w_commit  = (r_wr_state == WR_IDLE) && w_aw_have && w_w_have;
   assign w_b_hs    = r_bvalid && S_AXI_BREADY;

   // A channel handshaking on the commit edge is used straight from the bus
   assign w_wr_idx  = r_aw_held ? r_awidx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_wr_data = r_w_held  ? r_wdata : S_AXI_WDATA;
   assign w_wr_strb = r_w_held  ? r_wstrb : S_AXI_WSTRB;
   assign w_wr_ok   = int'(w_wr_idx) < NUM_REGS;

   // Write FSM state register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wr_state <= WR_IDLE;
      end else begin
         r_wr_state <= w_wr_state_next;
      end
   end

   // Write FSM next-state: commit once both halves are in, return on B handshake
   always_comb begin
      w_wr_state_next = r_wr_state;
      case (r_wr_state)
         WR_IDLE: if (w_commit) w_wr_state_next = WR_RESP;
         WR_RESP: if (w_b_hs)   w_wr_state_next = WR_IDLE;
         default:               w_wr_state_next = WR_IDLE;
      endcase
   end

   // Write FSM outputs: READY per unlatched channel, response raised on commit
   always_comb begin
      w_awready_next = 1'b0;
      w_wready_next  = 1'b0;
      w_aw_held_next = r_aw_held;
      w_w_held_next  = r_w_held;
      w_bvalid_next  = r_bvalid;
      w_bresp_next   = r_bresp;
      case (r_wr_state)
         WR_IDLE: begin
            if (w_commit) begin
               w_aw_held_next = 1'b0;
               w_w_held_next  = 1'b0;
               w_bvalid_next  = 1'b1;
               w_bresp_next   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
               w_aw_held_next = w_aw_have;
               w_w_held_next  = w_w_have;
               w_awready_next = !w_aw_have;
               w_wready_next  = !w_w_have;
            end
         end
         WR_RESP: begin
            if (w_b_hs) begin
               w_bvalid_next  = 1'b0;
               w_awready_next = 1'b1;
               w_wready_next  = 1'b1;
            end
         end
         default: begin
            w_bvalid_next = 1'b0;
         end
      endcase
   end

   // Register write-channel outputs and latch AW/W as they handshake
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_awidx   <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_awready <= w_awready_next;
         r_wready  <= w_wready_next;
         r_aw_held <= w_aw_held_next;
         r_w_held  <= w_w_held_next;
         r_bvalid  <= w_bvalid_next;
         r_bresp   <= w_bresp_next;
         if (w_aw_hs) begin
            r_awidx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;

   // ---------------------------------------------------------------
   // Read channel
   // ---------------------------------------------------------------
   assign w_ar_hs  = S_AXI_ARVALID && r_arready;
   assign w_r_hs   = r_rvalid && S_AXI_RREADY;
   assign w_rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_rd_ok  = int'(w_rd_idx) < NUM_REGS;
   assign w_rvalid_next = w_ar_hs ? 1'b1 : (w_r_hs ? 1'b0 : r_rvalid);

   // Single outstanding read: ARREADY is the registered complement of RVALID
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rvalid  <= w_rvalid_next;
         r_arready <= !w_rvalid_next;
         if (w_ar_hs) begin
            r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;

   pcap_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .i_wr_en    (w_commit),
      .i_wr_idx   (w_wr_idx),
      .i_wr_data  (w_wr_data),
      .i_wr_strb  (w_wr_strb),
      .i_rd_en    (w_ar_hs),
      .i_rd_idx   (w_rd_idx),
      .o_rd_data  (S_AXI_RDATA),
      .o_reg_q    (reg_q),
      .o_wr_pulse (reg_wr_pulse)
   );

endmodule

// File: tb/tb_pcap_axi_lite_regs.sv
// Bench for pcap_axi_lite_regs: a 4-register and a 3-register instance share
// one AXI master; expected B/R responses and write pulses are queued when
// stimulus is driven and compared when the DUTs produce them.
module tb_pcap_axi_lite_regs;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic        awready4, wready4, bvalid4, arready4, rvalid4;
   logic [1:0]  bresp4, rresp4;
   logic [31:0] rdata4;
   logic [127:0] regq4;
   logic [3:0]  pulse4;

   logic        awready3, wready3, bvalid3, arready3, rvalid3;
   logic [1:0]  bresp3, rresp3;
   logic [31:0] rdata3;
   logic [95:0] regq3;
   logic [2:0]  pulse3;

   typedef struct packed { logic [1:0] r4; logic [1:0] r3; } bexp_t;
   typedef struct packed { logic [3:0] p4; logic [2:0] p3; } pexp_t;
   typedef struct packed { logic [31:0] d4; logic [1:0] r4; logic [31:0] d3; logic [1:0] r3; } rexp_t;

   bexp_t bq[$];
   pexp_t pq[$];
   rexp_t rq[$];

   logic [31:0] m4 [4];
   logic [31:0] m3 [3];

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt = 0;
   int exp_b_edge = 0;

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

   pcap_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) u_dut4 (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready4),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready4),
      .S_AXI_BRESP(bresp4), .S_AXI_BVALID(bvalid4), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready4),
      .S_AXI_RDATA(rdata4), .S_AXI_RRESP(rresp4), .S_AXI_RVALID(rvalid4), .S_AXI_RREADY(rready),
      .reg_q(regq4), .reg_wr_pulse(pulse4)
   );

   pcap_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) u_dut3 (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready3),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready3),
      .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready3),
      .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(rready),
      .reg_q(regq3), .reg_wr_pulse(pulse3)
   );

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      if (s[0]) r[7:0]   = d[7:0];
      if (s[1]) r[15:8]  = d[15:8];
      if (s[2]) r[23:16] = d[23:16];
      if (s[3]) r[31:24] = d[31:24];
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic        prev_bv = 1'b0, prev_bready = 1'b0, prev_rv = 1'b0, prev_rready = 1'b0;
   logic [1:0]  prev_bresp = 2'b0, prev_rresp = 2'b0;
   logic [31:0] prev_rdata = 32'b0;

   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (bvalid4 && !prev_bv) begin
            if (pq.size() == 0) begin
               check_val("pulse_unexpected", {pulse4, pulse3}, 7'h0);
            end else begin
               pexp_t pe;
               pe = pq.pop_front();
               check_val("pulse4", pulse4, pe.p4);
               check_val("pulse3", pulse3, pe.p3);
               check_val("b_latency", cyc_cnt, exp_b_edge);
            end
         end else begin
            check_val("pulse_idle", {pulse4, pulse3}, 7'h0);
         end
         if (bvalid4 || bvalid3) begin
            check_val("busy_ready_low", {awready4, wready4, awready3, wready3}, 4'h0);
            check_val("bvalid_match", bvalid3, bvalid4);
         end
         if (prev_bv && !prev_bready) begin
            check_val("b_hold", {bvalid4, bresp4}, {1'b1, prev_bresp});
         end
         if (bvalid4 && bready) begin
            if (bq.size() == 0) begin
               check_val("b_unexpected", bvalid4, 1'b0);
            end else begin
               bexp_t be;
               be = bq.pop_front();
               $display("B  resp4=%b resp3=%b (exp %b/%b)", bresp4, bresp3, be.r4, be.r3);
               check_val("bresp4", bresp4, be.r4);
               check_val("bresp3", bresp3, be.r3);
            end
         end
         check_val("arready_vs_rvalid", arready4, !rvalid4);
         if (prev_rv && !prev_rready) begin
            check_val("r_hold", {rvalid4, rresp4, rdata4}, {1'b1, prev_rresp, prev_rdata});
         end
         if (rvalid4 && rready) begin
            if (rq.size() == 0) begin
               check_val("r_unexpected", rvalid4, 1'b0);
            end else begin
               rexp_t re;
               re = rq.pop_front();
               $display("R  data4=%h resp4=%b data3=%h resp3=%b", rdata4, rresp4, rdata3, rresp3);
               check_val("rdata4", rdata4, re.d4);
               check_val("rresp4", rresp4, re.r4);
               check_val("rdata3", rdata3, re.d3);
               check_val("rresp3", rresp3, re.r3);
            end
         end
         prev_bv     <= bvalid4;
         prev_bready <= bready;
         prev_bresp  <= bresp4;
         prev_rv     <= rvalid4;
         prev_rready <= rready;
         prev_rresp  <= rresp4;
         prev_rdata  <= rdata4;
      end else begin
         prev_bv <= 1'b0;
         prev_rv <= 1'b0;
      end
   end

   // ---------------- stimulus tasks ----------------
   // lead > 0: W presented lead cycles before AW; lead < 0: AW first
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdelay);
      bexp_t be;
      pexp_t pe;
      int idx, c, hs_edge;
      bit aw_done, w_done, aw_f, w_f, fire;
      idx = int'(addr[3:2]);
      be.r4 = OKAY;
      be.r3 = (idx < 3) ? OKAY : SLVERR;
      pe.p4 = 4'b0001 << idx;
      pe.p3 = (idx < 3) ? (3'b001 << idx) : 3'b000;
      bq.push_back(be);
      pq.push_back(pe);
      awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
      aw_done = 0; w_done = 0; c = 0; hs_edge = 0;
      while (!(aw_done && w_done) && c < 40) begin
         awvalid = !aw_done && (c >= lead);
         wvalid  = !w_done && (c >= -lead);
         @(negedge ACLK);
         aw_f = awvalid && awready4;
         w_f  = wvalid && wready4;
         if (aw_f || w_f) hs_edge = cyc_cnt + 1;
         exp_b_edge = hs_edge;
         @(posedge ACLK); #1;
         if (aw_f) aw_done = 1;
         if (w_f)  w_done = 1;
         c++;
      end
      awvalid = 0; wvalid = 0;
      check_val("wr_hs_done", {aw_done, w_done}, 2'b11);
      m4[idx] = bmerge(m4[idx], data, strb);
      if (idx < 3) m3[idx] = m4[idx];
      $display("W  addr=%h data=%h strb=%b lead=%0d bdelay=%0d", addr, data, strb, lead, bdelay);
      repeat (bdelay) begin @(posedge ACLK); #1; end
      bready = 1; c = 0; fire = 0;
      do begin
         @(negedge ACLK);
         fire = bvalid4;
         @(posedge ACLK); #1;
         c++;
      end while (!fire && c < 20);
      bready = 0;
      check_val("b_hs_done", fire, 1'b1);
      check_val("ready_after_b", {awready4, wready4}, 2'b11);
   endtask

   task automatic do_read(input logic [3:0] addr, input int rdelay);
      rexp_t re;
      int idx, c;
      bit f;
      idx = int'(addr[3:2]);
      re.d4 = m4[idx];
      re.r4 = OKAY;
      re.d3 = (idx < 3) ? m3[idx] : 32'h0;
      re.r3 = (idx < 3) ? OKAY : SLVERR;
      rq.push_back(re);
      araddr = addr; arprot = 3'($urandom); arvalid = 1; c = 0; f = 0;
      do begin
         @(negedge ACLK);
         f = arready4;
         @(posedge ACLK); #1;
         c++;
      end while (!f && c < 20);
      arvalid = 0;
      check_val("ar_hs_done", f, 1'b1);
      repeat (rdelay) begin @(posedge ACLK); #1; end
      rready = 1; c = 0; f = 0;
      do begin
         @(negedge ACLK);
         f = rvalid4;
         @(posedge ACLK); #1;
         c++;
      end while (!f && c < 20);
      rready = 0;
      check_val("r_hs_done", f, 1'b1);
   endtask

   task automatic check_regq(input string tag);
      check_val({tag, "_regq4"}, regq4, {m4[3], m4[2], m4[1], m4[0]});
      check_val({tag, "_regq3"}, {32'h0, regq3}, {32'h0, m3[2], m3[1], m3[0]});
   endtask

   // ---------------- test sequence ----------------
   logic [31:0] t1_data [4];

   initial begin
      ARESETN = 0;
      awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = 0; wstrb = 0;
      for (int i = 0; i < 4; i++) m4[i] = 32'h0;
      for (int i = 0; i < 3; i++) m3[i] = 32'h0;
      t1_data[0] = 32'h0101FFFF; t1_data[1] = 32'habcd0001;
      t1_data[2] = 32'hdead0011; t1_data[3] = 32'hbeef0011;

      // reset state
      @(posedge ACLK); @(negedge ACLK);
      check_val("rst_hs4", {awready4, wready4, bvalid4, bresp4, arready4, rvalid4, rresp4, rdata4, pulse4}, 0);
      check_val("rst_hs3", {awready3, wready3, bvalid3, bresp3, arready3, rvalid3, rresp3, rdata3, pulse3}, 0);
      check_regq("rst");
      #1 ARESETN = 1;
      @(posedge ACLK); #1;
      check_val("ready_after_rst", {awready4, wready4, arready4, awready3, wready3, arready3}, 6'h3F);

      // 1: basic writes with readback (0xC also exercises SLVERR on the 3-reg DUT)
      for (int i = 0; i < 4; i++) begin
         do_write(4'(i * 4), t1_data[i], 4'hF, 0, 0);
         do_read(4'(i * 4), i % 2 * 2);
      end
      check_regq("t1");

      // 2: byte strobes, and an all-zero strobe
      do_write(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0);
      do_write(4'h0, 32'h12345678, 4'b0101, 0, 0);
      do_read(4'h0, 0);
      do_write(4'h8, 32'h99999999, 4'b0000, 0, 1);
      do_read(4'h8, 0);

      // 3: W ahead of AW, together, and AW ahead of W
      do_write(4'h8, 32'h5a5ac3c3, 4'hF, 3, 0);
      do_write(4'hC, 32'h0f0f1234, 4'hF, 0, 0);
      do_write(4'h2, 32'h77665544, 4'b1100, -2, 0);
      do_read(4'h8, 0);
      do_read(4'h3, 0);

      // 4: B back-pressure, then an immediate follow-on write
      do_write(4'h4, 32'h13572468, 4'hF, 0, 5);
      do_write(4'h4, 32'habcd0001, 4'hF, 0, 0);

      // 5: out-of-range index on the 3-reg DUT, held R, ignored low address bits
      do_read(4'hC, 3);
      do_read(4'hD, 0);
      do_read(4'h5, 1);
      check_regq("t5");

      // 6: read and write to the same register on the same edge
      fork
         do_write(4'h4, 32'hAAAA5555, 4'hF, 0, 0);
         do_read(4'h4, 0);
      join
      do_read(4'h4, 0);

      // 6b: asynchronous reset in the middle of a write with a read outstanding
      awaddr = 4'h0; awvalid = 1; araddr = 4'h8; arvalid = 1;
      @(negedge ACLK); @(posedge ACLK); #1;
      awvalid = 0; arvalid = 0;
      check_val("pre_rst_busy", {awready4, rvalid4}, 2'b01);
      #2 ARESETN = 0;
      #1;
      check_val("async_rst4", {awready4, wready4, bvalid4, bresp4, arready4, rvalid4, rresp4, rdata4, pulse4}, 0);
      check_val("async_rst3", {awready3, wready3, bvalid3, bresp3, arready3, rvalid3, rresp3, rdata3, pulse3}, 0);
      for (int i = 0; i < 4; i++) m4[i] = 32'h0;
      for (int i = 0; i < 3; i++) m3[i] = 32'h0;
      check_regq("async_rst");
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
      @(negedge ACLK); #1 ARESETN = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge ACLK);
         check_val("no_b_after_rst", {bvalid4, bvalid3, pulse4, pulse3}, 0);
      end
      wvalid = 0;
      @(posedge ACLK); #1;
      do_read(4'h0, 0);
      check_regq("end");

      repeat (4) @(posedge ACLK);
      check_val("bq_empty", bq.size(), 0);
      check_val("pq_empty", pq.size(), 0);
      check_val("rq_empty", rq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
